vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised raster timing generator for the graphic controller. Produces pixel/line counters, active-video enable, horizontal/vertical sync and line/frame markers for any mode set by per-axis active, porch and sync parameters. Also generates the pixel-rate tick from the system clock and can delay its sync/enable outputs to match a downstream pixel pipeline. Sits between the system clock and the pixel-generation and DAC/output stages, replacing the fixed 640x480 sync generator.

## Interface
- CLK_DIV, 2: system clocks per pixel (>=1)
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal region lengths in pixels
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical region lengths in lines
- H_POL, 0 / V_POL, 0: sync active level (0 = active-low)
- CW, 11: counter width; H_TOTAL and V_TOTAL must fit in CW bits
- SYNC_DELAY, 0: pixel ticks of delay on V_EN/H_SYNC/V_SYNC/LINE_START/FRAME_START (0..15)
- FW, 8: frame counter width
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- EN  in  1  run enable; 0 freezes timing
- PIX_TICK  out  1  one-CLOCK pulse per pixel period
- H_COUNTER  out  CW  current pixel within line
- V_COUNTER  out  CW  current line within frame
- V_EN  out  1  inside active area
- H_SYNC, V_SYNC  out  1  sync outputs at configured polarity
- LINE_START  out  1  one-CLOCK pulse at start of each line
- FRAME_START  out  1  one-CLOCK pulse at start of each frame
- FRAME_COUNT  out  FW  frames completed, wraps

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Region order per axis: active, front porch, sync, back porch.
- Divider counts 0..CLK_DIV-1 while EN=1; PIX_TICK high in the cycle the divider equals CLK_DIV-1. CLK_DIV=1: PIX_TICK high every cycle while EN=1.
- On the edge ending a PIX_TICK cycle: H_COUNTER increments; at H_TOTAL-1 wraps to 0 and V_COUNTER increments; V_COUNTER at V_TOTAL-1 wraps to 0 on that same edge and FRAME_COUNT increments (modulo 2^FW).
- Decode (from counter values): active = H<H_ACTIVE and V<V_ACTIVE; hs = H in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vs same on V axis; ls = H==0; fs = H==0 and V==0.
- Flags registered: with SYNC_DELAY=0 outputs match the counter values visible in the same cycle. SYNC_DELAY=N: flags pass through an N-stage shift register advanced on PIX_TICK.
- LINE_START/FRAME_START: high only in the first CLOCK cycle a decoded ls/fs value appears at the output (not for every cycle of the pixel).
- EN=0: divider cleared, counters/FRAME_COUNT/delay line hold, PIX_TICK=0, V_EN=0, syncs inactive, pulses 0. EN=1 resumes from held position.
- Elaboration error if any sync length is 0, CLK_DIV<1, totals overflow CW, or SYNC_DELAY>15.

## Timing
- Reset (asynchronous assert, any cycle): divider, counters, FRAME_COUNT, delay line = 0; PIX_TICK=0, V_EN=0, H_SYNC=~H_POL, V_SYNC=~V_POL, pulses 0.
- First CLOCK edge after RESET release with EN=1: outputs present decode of (0,0): V_EN=1, LINE_START=1, FRAME_START=1 (SYNC_DELAY=0).
- First PIX_TICK occurs CLK_DIV cycles after release.
- Frame period = H_TOTAL*V_TOTAL*CLK_DIV CLOCK cycles (defaults: 800*525*2 = 840000).
- Reset mid-frame: all state clears immediately; timing restarts at (0,0).
- EN and RESET both high: RESET wins.

## Structure
- Package vga_timing_pkg: timing-params struct type (active/fp/sync/bp per axis), default 640x480@60 constant, total/sync-start helper functions.
- Sub-module timing_axis: one generic wrapping counter with carry-in/carry-out and region decode, instantiated for H (carry-in = PIX_TICK) and V (carry-in = H wrap).

## Test plan
- Defaults, EN=1 after reset: H_SYNC low for exactly 192 CLOCKs starting when H_COUNTER=656; V_EN high 1280 CLOCKs per active line.
- Defaults: FRAME_START pulses exactly 840000 CLOCKs apart; V_SYNC low during V_COUNTER 490..491; FRAME_COUNT 255 -> 0 wraps.
- CLK_DIV=1, H_POL=1, V_POL=1: PIX_TICK constant high, syncs active-high, line = 800 CLOCKs.
- SYNC_DELAY=3: H_SYNC falling edge seen when H_COUNTER=659; V_EN falls at H_COUNTER=643.
- EN low for 1000 CLOCKs at H_COUNTER=300: counters hold 300, V_EN=0, syncs inactive; on EN high, H_COUNTER reaches 301 after CLK_DIV cycles.
- RESET asserted asynchronously mid-line at V_COUNTER=200: outputs go to reset values without a clock edge; after release FRAME_START pulses on first edge.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared types and helpers for the raster timing generator: per-axis region
// lengths, the default 640x480@60 mode and derived-position helpers.
package vga_timing_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } axis_t;

  typedef struct packed {
    axis_t h;
    axis_t v;
  } timing_t;

  // Decoded raster flags carried through the optional sync delay line.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } flags_t;

  localparam timing_t VGA_640X480 = '{
    h: '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48},
    v: '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33}
  };

  function automatic axis_t make_axis(input int active, input int fp,
                                      input int sync, input int bp);
    axis_t a;
    a.active = 16'(active);
    a.fp     = 16'(fp);
    a.sync   = 16'(sync);
    a.bp     = 16'(bp);
    return a;
  endfunction

  function automatic int axis_total(input axis_t a);
    return int'(a.active) + int'(a.fp) + int'(a.sync) + int'(a.bp);
  endfunction

  function automatic int sync_start(input axis_t a);
    return int'(a.active) + int'(a.fp);
  endfunction

  function automatic int sync_end(input axis_t a);
    return sync_start(a) + int'(a.sync);
  endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: a wrapping position counter advanced by carry_in, with
// region decode of both the current and the about-to-be-loaded position.
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter axis_t CFG = VGA_640X480.h,
  parameter int    CW  = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          carry_in,
  output logic [CW-1:0] count,
  output logic          carry_out,
  output logic          active_now,
  output logic          sync_now,
  output logic          start_now,
  output logic          active_next,
  output logic          sync_next,
  output logic          start_next
);

  localparam int            TOTAL      = axis_total(CFG);
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END    = CW'(int'(CFG.active));
  localparam logic [CW-1:0] SYNC_BEGIN = CW'(sync_start(CFG));
  localparam logic [CW-1:0] SYNC_STOP  = CW'(sync_end(CFG));

  logic [CW-1:0] count_next;

  // Returns {start, sync, active} for a position on this axis.
  function automatic logic [2:0] decode(input logic [CW-1:0] c);
    return {c == '0, (c >= SYNC_BEGIN) && (c < SYNC_STOP), c < ACT_END};
  endfunction

  assign carry_out = carry_in && (count == LAST);

  always_comb begin
    count_next = count;
    if (carry_in) begin
      count_next = (count == LAST) ? '0 : count + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign {start_now, sync_now, active_now}    = decode(count);
  assign {start_next, sync_next, active_next} = decode(count_next);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-rate divider, H/V position
// counters, frame counter and registered sync/enable/marker outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC_LEN = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC_LEN = 2,
  parameter int V_BP       = 33,
  parameter int H_POL      = 0,
  parameter int V_POL      = 0,
  parameter int CW         = 11,
  parameter int SYNC_DELAY = 0,
  parameter int FW         = 8
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          EN,
  output logic          PIX_TICK,
  output logic [CW-1:0] H_COUNTER,
  output logic [CW-1:0] V_COUNTER,
  output logic          V_EN,
  output logic          H_SYNC,
  output logic          V_SYNC,
  output logic          LINE_START,
  output logic          FRAME_START,
  output logic [FW-1:0] FRAME_COUNT
);

  localparam axis_t H_CFG   = make_axis(H_ACTIVE, H_FP, H_SYNC_LEN, H_BP);
  localparam axis_t V_CFG   = make_axis(V_ACTIVE, V_FP, V_SYNC_LEN, V_BP);
  localparam int    H_TOTAL = axis_total(H_CFG);
  localparam int    V_TOTAL = axis_total(V_CFG);
  localparam int    DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic  H_LVL   = (H_POL != 0);
  localparam logic  V_LVL   = (V_POL != 0);

  if (H_SYNC_LEN < 1 || V_SYNC_LEN < 1) begin : g_bad_sync
    $error("vga_timing_gen: sync lengths must be non-zero");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if ((H_TOTAL >> CW) != 0 || (V_TOTAL >> CW) != 0) begin : g_bad_cw
    $error("vga_timing_gen: line/frame totals do not fit in CW bits");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 15) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be 0..15");
  end

  logic [DW-1:0] div;
  logic          tick;
  logic          h_wrap, v_wrap;
  logic          h_act, h_hs, h_ls, v_act, v_vs, v_ls;
  logic          h_act_n, h_hs_n, h_ls_n, v_act_n, v_vs_n, v_ls_n;
  flags_t        cur_flags, next_flags, shown_next;
  logic          ven_q, hs_q, vs_q, shown;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      div <= '0;
    end else if (!EN || div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  // Combinational so that EN low silences the tick in the same cycle.
  assign tick     = EN && !RESET && (div == DIV_LAST);
  assign PIX_TICK = tick;

  timing_axis #(.CFG(H_CFG), .CW(CW)) u_h_axis (
    .clk        (CLOCK),
    .rst        (RESET),
    .carry_in   (tick),
    .count      (H_COUNTER),
    .carry_out  (h_wrap),
    .active_now (h_act),
    .sync_now   (h_hs),
    .start_now  (h_ls),
    .active_next(h_act_n),
    .sync_next  (h_hs_n),
    .start_next (h_ls_n)
  );

  timing_axis #(.CFG(V_CFG), .CW(CW)) u_v_axis (
    .clk        (CLOCK),
    .rst        (RESET),
    .carry_in   (h_wrap),
    .count      (V_COUNTER),
    .carry_out  (v_wrap),
    .active_now (v_act),
    .sync_now   (v_vs),
    .start_now  (v_ls),
    .active_next(v_act_n),
    .sync_next  (v_vs_n),
    .start_next (v_ls_n)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      FRAME_COUNT <= '0;
    end else if (v_wrap) begin
      FRAME_COUNT <= FRAME_COUNT + FW'(1);
    end
  end

  always_comb begin
    cur_flags.active  = h_act && v_act;
    cur_flags.hs      = h_hs;
    cur_flags.vs      = v_vs;
    cur_flags.ls      = h_ls;
    cur_flags.fs      = h_ls && v_ls;
    next_flags.active = h_act_n && v_act_n;
    next_flags.hs     = h_hs_n;
    next_flags.vs     = v_vs_n;
    next_flags.ls     = h_ls_n;
    next_flags.fs     = h_ls_n && v_ls_n;
  end

  // shown_next is the flag set the output register holds after this edge:
  // either the new pixel's decode or the entry leaving the delay line.
  if (SYNC_DELAY == 0) begin : g_no_delay
    assign shown_next = tick ? next_flags : cur_flags;
  end else begin : g_delay
    flags_t dl       [SYNC_DELAY];
    flags_t stage_in [SYNC_DELAY];

    always_comb begin
      stage_in[0] = cur_flags;
      for (int k = 1; k < SYNC_DELAY; k++) begin
        stage_in[k] = dl[k-1];
      end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
        dl <= '{default: '0};
      end else if (tick) begin
        dl <= stage_in;
      end
    end

    assign shown_next = tick ? stage_in[SYNC_DELAY-1] : dl[SYNC_DELAY-1];
  end

  // Markers fire only when a new pixel's flags are loaded, or on the first
  // edge after the outputs were blanked by reset or EN low.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      ven_q       <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
      shown       <= 1'b0;
    end else if (!EN) begin
      ven_q       <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
      shown       <= 1'b0;
    end else begin
      ven_q       <= shown_next.active;
      hs_q        <= shown_next.hs;
      vs_q        <= shown_next.vs;
      LINE_START  <= shown_next.ls && (tick || !shown);
      FRAME_START <= shown_next.fs && (tick || !shown);
      shown       <= 1'b1;
    end
  end

  assign V_EN   = ven_q;
  assign H_SYNC = hs_q ? H_LVL : ~H_LVL;
  assign V_SYNC = vs_q ? V_LVL : ~V_LVL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: directed line-level checks on the default mode and
// randomized EN/reset stimulus on two small modes against a position model.
module tb_vga_timing_gen;

  localparam int CW  = 11;
  localparam int HA  = 16, HF = 2, HSW = 3, HB = 2;
  localparam int VA  = 6,  VF = 1, VSW = 2, VB = 2;
  localparam int HT  = HA + HF + HSW + HB;
  localparam int VT  = VA + VF + VSW + VB;
  localparam int FT  = HT * VT;

  // clock / reset block
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, en0, rst1, en1;

  logic          d0_tick, d0_ven, d0_hs, d0_vs, d0_ls, d0_fs;
  logic [CW-1:0] d0_h, d0_v;
  logic [7:0]    d0_fc;
  logic          d1_tick, d1_ven, d1_hs, d1_vs, d1_ls, d1_fs;
  logic [CW-1:0] d1_h, d1_v;
  logic [1:0]    d1_fc;
  logic          d2_tick, d2_ven, d2_hs, d2_vs, d2_ls, d2_fs;
  logic [CW-1:0] d2_h, d2_v;
  logic [7:0]    d2_fc;

  vga_timing_gen dut0 (
    .CLOCK(clk), .RESET(rst0), .EN(en0), .PIX_TICK(d0_tick),
    .H_COUNTER(d0_h), .V_COUNTER(d0_v), .V_EN(d0_ven), .H_SYNC(d0_hs),
    .V_SYNC(d0_vs), .LINE_START(d0_ls), .FRAME_START(d0_fs), .FRAME_COUNT(d0_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC_LEN(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC_LEN(VSW), .V_BP(VB), .FW(2)
  ) dut1 (
    .CLOCK(clk), .RESET(rst1), .EN(en1), .PIX_TICK(d1_tick),
    .H_COUNTER(d1_h), .V_COUNTER(d1_v), .V_EN(d1_ven), .H_SYNC(d1_hs),
    .V_SYNC(d1_vs), .LINE_START(d1_ls), .FRAME_START(d1_fs), .FRAME_COUNT(d1_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC_LEN(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC_LEN(VSW), .V_BP(VB),
    .H_POL(1), .V_POL(1), .SYNC_DELAY(3)
  ) dut2 (
    .CLOCK(clk), .RESET(rst1), .EN(en1), .PIX_TICK(d2_tick),
    .H_COUNTER(d2_h), .V_COUNTER(d2_v), .V_EN(d2_ven), .H_SYNC(d2_hs),
    .V_SYNC(d2_vs), .LINE_START(d2_ls), .FRAME_START(d2_fs), .FRAME_COUNT(d2_fc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
  endtask

  // Reference model: pixels elapsed since reset plus divider phase; the
  // shown flags belong to the pixel SYNC_DELAY positions back.
  int m_div [2];
  int m_total [2];
  int m_prev_id [2];
  bit m_show [2];
  bit m_prev_show [2];
  int cd [2];
  int dly [2];
  int fwm [2];
  bit pol [2];

  task automatic model_reset(input int m);
    m_div[m] = 0; m_total[m] = 0; m_show[m] = 0;
    m_prev_show[m] = 0; m_prev_id[m] = 0;
  endtask

  task automatic model_edge(input int m);
    bit t;
    m_prev_show[m] = m_show[m];
    m_prev_id[m]   = m_total[m] - dly[m];
    t = en1 && (m_div[m] == cd[m] - 1);
    m_div[m] = en1 ? (m_div[m] + 1) % cd[m] : 0;
    if (t) m_total[m]++;
    m_show[m] = en1;
  endtask

  task automatic check_model(input int m, input logic tick, input logic [CW-1:0] h,
                             input logic [CW-1:0] v, input logic [7:0] fc,
                             input logic ven, input logic hs, input logic vs,
                             input logic ls, input logic fs);
    int p, id, q, hq, vq;
    bit on, newpix, a, hsy, vsy;
    string n;
    n  = $sformatf("d%0d_", m + 1);
    p  = m_total[m] % FT;
    id = m_total[m] - dly[m];
    on = m_show[m] && (id >= 0);
    q  = on ? id % FT : 0;
    hq = q % HT;
    vq = q / HT;
    a   = on && hq < HA && vq < VA;
    hsy = on && hq >= HA + HF && hq < HA + HF + HSW;
    vsy = on && vq >= VA + VF && vq < VA + VF + VSW;
    newpix = !(m_prev_show[m] && m_prev_id[m] == id);
    check({n, "pix_tick"}, tick, en1 && !rst1 && (m_div[m] == cd[m] - 1));
    check({n, "h_counter"}, h, p % HT);
    check({n, "v_counter"}, v, p / HT);
    check({n, "frame_count"}, fc, (m_total[m] / FT) % (1 << fwm[m]));
    check({n, "v_en"}, ven, a);
    check({n, "h_sync"}, hs, hsy ? pol[m] : !pol[m]);
    check({n, "v_sync"}, vs, vsy ? pol[m] : !pol[m]);
    check({n, "line_start"}, ls, on && hq == 0 && newpix);
    check({n, "frame_start"}, fs, on && q == 0 && newpix);
  endtask

  task automatic check_both();
    check_model(0, d1_tick, d1_h, d1_v, {6'b0, d1_fc}, d1_ven, d1_hs, d1_vs, d1_ls, d1_fs);
    check_model(1, d2_tick, d2_h, d2_v, d2_fc, d2_ven, d2_hs, d2_vs, d2_ls, d2_fs);
  endtask

  initial begin
    int cnt, ven_n, hs_n, vs_n, ls_n, first_hs;
    cd[0] = 2; dly[0] = 0; fwm[0] = 2; pol[0] = 1'b0;
    cd[1] = 1; dly[1] = 3; fwm[1] = 8; pol[1] = 1'b1;
    rst0 = 1'b1; en0 = 1'b1; rst1 = 1'b1; en1 = 1'b1;
    model_reset(0); model_reset(1);
    repeat (3) @(negedge clk);

    check("d0_reset_h", d0_h, 0);
    check("d0_reset_v_en", d0_ven, 0);
    check("d0_reset_h_sync", d0_hs, 1);
    check("d0_reset_v_sync", d0_vs, 1);
    check("d0_reset_tick", d0_tick, 0);
    check("d0_reset_frame_start", d0_fs, 0);
    check_both();

    rst0 = 1'b0;
    @(negedge clk);
    check("d0_first_frame_start", d0_fs, 1);
    check("d0_first_line_start", d0_ls, 1);
    check("d0_first_v_en", d0_ven, 1);
    check("d0_first_h", d0_h, 0);
    check("d0_first_tick", d0_tick, 1);
    @(negedge clk);
    check("d0_ls_single_cycle", d0_ls, 0);
    check("d0_second_h", d0_h, 1);
    check("d0_second_tick", d0_tick, 0);

    cnt = 0;
    while (d0_v != 1 && cnt < 4000) begin @(negedge clk); cnt++; end
    check("d0_reach_line1", cnt < 4000, 1);
    ven_n = 0; hs_n = 0; vs_n = 0; ls_n = 0; first_hs = -1; cnt = 0;
    while (d0_v == 1 && cnt < 4000) begin
      if (d0_ven) ven_n++;
      if (!d0_hs) begin
        if (hs_n == 0) first_hs = int'(d0_h);
        hs_n++;
      end
      if (!d0_vs) vs_n++;
      if (d0_ls) ls_n++;
      @(negedge clk); cnt++;
    end
    check("d0_line_clocks", cnt, 1600);
    check("d0_v_en_clocks", ven_n, 1280);
    check("d0_h_sync_clocks", hs_n, 192);
    check("d0_h_sync_start_h", first_hs, 656);
    check("d0_v_sync_clocks_line1", vs_n, 0);
    check("d0_line_start_count", ls_n, 1);

    cnt = 0;
    while (d0_h != 300 && cnt < 1000) begin @(negedge clk); cnt++; end
    check("d0_reach_h300", cnt < 1000, 1);
    en0 = 1'b0;
    repeat (1000) @(negedge clk);
    check("d0_hold_h", d0_h, 300);
    check("d0_hold_v", d0_v, 2);
    check("d0_hold_v_en", d0_ven, 0);
    check("d0_hold_h_sync", d0_hs, 1);
    check("d0_hold_v_sync", d0_vs, 1);
    check("d0_hold_tick", d0_tick, 0);
    check("d0_hold_line_start", d0_ls, 0);
    en0 = 1'b1;
    @(negedge clk);
    check("d0_resume_h_1", d0_h, 300);
    @(negedge clk);
    check("d0_resume_h_2", d0_h, 301);

    #2 rst0 = 1'b1;
    #1;
    check("d0_async_h", d0_h, 0);
    check("d0_async_v", d0_v, 0);
    check("d0_async_v_en", d0_ven, 0);
    check("d0_async_h_sync", d0_hs, 1);
    check("d0_async_tick", d0_tick, 0);
    @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    check("d0_rst_frame_start", d0_fs, 1);
    check("d0_rst_line_start", d0_ls, 1);
    check("d0_rst_v_en", d0_ven, 1);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      check_both();
      en1 = ($urandom_range(0, 9) != 0);
      if (rst1) begin
        rst1 = 1'b0;
      end else if ($urandom_range(0, 1499) == 0) begin
        #2 rst1 = 1'b1;
        model_reset(0); model_reset(1);
        #1 check_both();
      end
      @(posedge clk);
      if (!rst1) begin
        model_edge(0);
        model_edge(1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
